// File: rtl/audio_adc_rx.sv
// I2S / left-justified stereo ADC receiver with a show-ahead {left,right} pair FIFO, all on clk.
// Defining AUDIO_ADC_RX_DROPCNT_EN adds the saturating drop_cnt output.
module audio_adc_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter bit MODE_LJ      = 1'b0,
  parameter int FIFO_AW      = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      read,
  output logic [2*SAMPLE_WIDTH-1:0] readdata,
  output logic                      empty,
  output logic                      full,
  output logic [FIFO_AW:0]          level,
  output logic                      overflow,
`ifdef AUDIO_ADC_RX_DROPCNT_EN
  output logic [15:0]               drop_cnt,
`endif
  input  logic                      bclk,
  input  logic                      adclrc,
  input  logic                      adcdat
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0]    LAST_BIT = CW'(SAMPLE_WIDTH - 1);
  localparam logic [FIFO_AW:0] DEPTH_L  = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  logic bclk_p0, bclk_p1, bclk_p2;
  logic lrc_p0, lrc_p1;
  logic dat_p0, dat_p1;
  logic lrc_last, lrc_init;
  logic bit_evt, lrc_chg;

  state_t                          state, state_nxt;
  logic [CW-1:0]                   bit_cnt, cnt_nxt;
  logic                            chan, chan_nxt;
  logic                            shift_en, word_done;
  logic [SAMPLE_WIDTH-1:0]         shreg;
  logic signed [SAMPLE_WIDTH-1:0]  word;
  logic signed [SAMPLE_WIDTH-1:0]  left_word;
  logic                            left_vld;
  logic [2*SAMPLE_WIDTH-1:0]       pair_p1;
  logic                            vld_p1;

  logic [2*SAMPLE_WIDTH-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0]          wr_ptr, rd_ptr;
  logic                      do_read, do_push, drop;

`ifdef AUDIO_ADC_RX_DROPCNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // ---- stage p0/p1: two-flop synchronisers, p2: previous bclk for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_p0 <= 1'b0;
      bclk_p1 <= 1'b0;
      bclk_p2 <= 1'b0;
      lrc_p0  <= 1'b0;
      lrc_p1  <= 1'b0;
    end else begin
      bclk_p0 <= bclk;
      bclk_p1 <= bclk_p0;
      bclk_p2 <= bclk_p1;
      lrc_p0  <= adclrc;
      lrc_p1  <= lrc_p0;
    end
  end

  always_ff @(posedge clk) begin
    dat_p0 <= adcdat;
    dat_p1 <= dat_p0;
  end

  assign bit_evt = bclk_p1 & ~bclk_p2;
  // The very first bit event only records adclrc; a change needs a previous sample.
  assign lrc_chg = bit_evt & lrc_init & (lrc_p1 != lrc_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrc_last <= 1'b0;
      lrc_init <= 1'b0;
    end else if (bit_evt) begin
      lrc_last <= lrc_p1;
      lrc_init <= 1'b1;
    end
  end

  // ---- bit-level FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      chan    <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      bit_cnt <= '0;
      chan    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      chan    <= chan_nxt;
    end
  end

  // In I2S the lrc-change event still carries the previous slot's LSB, so that
  // event is the single skipped bit; in LJ it already carries the new MSB.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    chan_nxt  = chan;
    shift_en  = 1'b0;
    word_done = 1'b0;
    if (bit_evt) begin
      if (lrc_chg) begin
        chan_nxt  = lrc_p1;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
        shift_en  = MODE_LJ;
      end else if (state == SHIFT) begin
        shift_en = 1'b1;
      end
      if (shift_en) begin
        if (cnt_nxt == LAST_BIT) begin
          word_done = 1'b1;
          state_nxt = PAD;
        end
        cnt_nxt = cnt_nxt + 1'b1;
      end
    end
  end

  // Stale bits of an abandoned word fall off the top after SAMPLE_WIDTH shifts.
  assign word = {shreg[SAMPLE_WIDTH-2:0], dat_p1};

  always_ff @(posedge clk) begin
    if (shift_en)
      shreg <= word;
    if (word_done && !chan_nxt)
      left_word <= word;
    if (word_done && chan_nxt && left_vld)
      pair_p1 <= {left_word, word};
  end

  // ---- stage p1: frame assembly, push request one clk after the right word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_vld <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (clear) begin
      left_vld <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (word_done) begin
        if (!chan_nxt) begin
          left_vld <= 1'b1;
        end else if (left_vld) begin
          vld_p1   <= 1'b1;
          left_vld <= 1'b0;
        end
      end
    end
  end

  // ---- FIFO
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == DEPTH_L);
  assign readdata = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

  assign do_read = read & ~empty;
  assign do_push = vld_p1 & (~full | do_read);
  assign drop    = vld_p1 & full & ~do_read;

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr[FIFO_AW-1:0]] <= pair_p1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_read)
        rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

`ifdef AUDIO_ADC_RX_DROPCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_cnt <= '0;
    else if (clear)
      drop_cnt <= '0;
    else if (drop)
      drop_cnt <= sat_inc(drop_cnt);
  end
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: an I2S instance checked against a queue model, plus an LJ instance.
module tb_audio_adc_rx;
  localparam int SW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, clear, read_i, read_l;
  logic bclk_i, lrc_i, dat_i, bclk_l, lrc_l, dat_l;
  logic [2*SW-1:0] rd_i, rd_l;
  logic empty_i, full_i, ovf_i, empty_l, full_l, ovf_l;
  logic [AW:0] level_i, level_l;
`ifdef AUDIO_ADC_RX_DROPCNT_EN
  logic [15:0] drop_i, drop_l;
`endif

  audio_adc_rx #(.SAMPLE_WIDTH(SW), .MODE_LJ(1'b0), .FIFO_AW(AW)) dut_i2s (
    .clk(clk), .reset_n(reset_n), .clear(clear), .read(read_i),
    .readdata(rd_i), .empty(empty_i), .full(full_i), .level(level_i), .overflow(ovf_i),
`ifdef AUDIO_ADC_RX_DROPCNT_EN
    .drop_cnt(drop_i),
`endif
    .bclk(bclk_i), .adclrc(lrc_i), .adcdat(dat_i));

  audio_adc_rx #(.SAMPLE_WIDTH(SW), .MODE_LJ(1'b1), .FIFO_AW(AW)) dut_lj (
    .clk(clk), .reset_n(reset_n), .clear(clear), .read(read_l),
    .readdata(rd_l), .empty(empty_l), .full(full_l), .level(level_l), .overflow(ovf_l),
`ifdef AUDIO_ADC_RX_DROPCNT_EN
    .drop_cnt(drop_l),
`endif
    .bclk(bclk_l), .adclrc(lrc_l), .adcdat(dat_l));

  int vectors = 0;
  int miscompares = 0;

  // Model: the FIFO as a bounded queue of expected pairs plus the sticky flags.
  logic [31:0] q[$];
  bit          m_ovf = 1'b0;
  int          m_drops = 0;
  bit          settled = 1'b0;

  int hook_kind = 0;  // 1 = clear pulse, 2 = reset pulse, 3 = read in the push cycle
  int hook_ch   = 0;
  int hook_pos  = 0;
  bit lj_sel    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic [31:0] p);
    if (q.size() == DEPTH) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end else begin
      q.push_back(p);
    end
  endtask

  task automatic model_pop();
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  always @(negedge clk) begin
    if (settled) begin
      check("level", 32'(level_i), 32'(q.size()));
      check("empty", 32'(empty_i), 32'(q.size() == 0));
      check("full", 32'(full_i), 32'(q.size() == DEPTH));
      check("overflow", 32'(ovf_i), 32'(m_ovf));
      if (q.size() > 0) check("head", rd_i, q[0]);
`ifdef AUDIO_ADC_RX_DROPCNT_EN
      check("drop_cnt", 32'(drop_i), 32'(m_drops));
`endif
    end
  end

  function automatic logic [15:0] fl(input int i);
    return 16'(32'h4000 + i * 3);
  endfunction

  function automatic logic [15:0] fr(input int i);
    return 16'(32'h8001 ^ (i * 16));
  endfunction

  // One bclk period: 4 clk low (data/lrc change), 4 clk high (rising edge samples).
  task automatic send_bit(input logic l, input logic d, input int kind);
    if (lj_sel) begin bclk_l = 1'b0; lrc_l = l; dat_l = d; end
    else begin bclk_i = 1'b0; lrc_i = l; dat_i = d; end
    if (kind == 1) begin
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      repeat (2) @(posedge clk);
    end else if (kind == 2) begin
      reset_n = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
    end else begin
      repeat (4) @(posedge clk);
    end
    #1;
    if (lj_sel) bclk_l = 1'b1; else bclk_i = 1'b1;
    if (kind == 3) begin
      // two sync flops, one FSM cycle, one push-request cycle
      repeat (3) @(posedge clk); #1 read_i = 1'b1;
      @(posedge clk); #1 read_i = 1'b0;
    end else begin
      repeat (4) @(posedge clk); #1;
    end
  endtask

  task automatic send_slot(input logic ch, input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int   k;
      int   kind;
      logic d;
      k = lj_sel ? i : i - 1;
      d = (k >= 0 && k < SW) ? w[SW-1-k] : 1'($urandom_range(0, 1));
      kind = (hook_kind != 0 && hook_ch == int'(ch) && hook_pos == i) ? hook_kind : 0;
      send_bit(ch, d, kind);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    send_frame(l, r);
    model_push({l, r});
  endtask

  task automatic idle(input int n);
    settled = 1'b1;
    repeat (n) @(posedge clk);
    #1 settled = 1'b0;
  endtask

  task automatic do_read();
    read_i = 1'b1;
    @(posedge clk); #1 read_i = 1'b0;
    model_pop();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; read_i = 1'b0; read_l = 1'b0;
    bclk_i = 1'b0; lrc_i = 1'b0; dat_i = 1'b0;
    bclk_l = 1'b0; lrc_l = 1'b0; dat_l = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(4);
    check("rst_readdata", rd_i, 32'h0);
    check("rst_empty", 32'(empty_i), 32'd1);
    check("rst_level", 32'(level_i), 32'd0);
    check("rst_full", 32'(full_i), 32'd0);
    check("rst_overflow", 32'(ovf_i), 32'd0);

    // I2S: preamble right slot gives the first lrc change at the left slot
    send_slot(1'b1, 16'h0000, 32);
    push_frame(16'hA5C3, 16'h1234);
    idle(4);
    check("i2s_pair", rd_i, 32'hA5C31234);
    check("i2s_level", 32'(level_i), 32'd1);

    // short left slot: the following right word has no partner
    send_slot(1'b0, 16'hFFFF, 8);
    send_slot(1'b1, 16'h5555, 32);
    idle(4);
    check("short_level", 32'(level_i), 32'd1);
    push_frame(16'h0F0F, 16'hF0F0);
    idle(4);
    check("after_short_level", 32'(level_i), 32'd2);
    do_read(); idle(2);
    check("second_pair", rd_i, 32'h0F0FF0F0);
    do_read(); idle(2);
    check("drained_empty", 32'(empty_i), 32'd1);
    do_read(); idle(2);
    check("read_empty_level", 32'(level_i), 32'd0);

    // LJ instance: same words, one bclk earlier relative to lrc
    lj_sel = 1'b1;
    send_slot(1'b1, 16'h0000, 32);
    send_slot(1'b0, 16'hA5C3, 32);
    send_slot(1'b1, 16'h1234, 32);
    lj_sel = 1'b0;
    idle(4);
    check("lj_pair", rd_l, 32'hA5C31234);
    check("lj_level", 32'(level_l), 32'd1);

    // fill, push-with-read at full, then one dropped frame
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_clear();
    for (int i = 0; i < 64; i++) push_frame(fl(i), fr(i));
    idle(4);
    check("fill_level", 32'(level_i), 32'd64);
    check("fill_full", 32'(full_i), 32'd1);
    hook_kind = 3; hook_ch = 1; hook_pos = 16;
    send_frame(fl(64), fr(64));
    hook_kind = 0;
    model_pop();
    model_push({fl(64), fr(64)});
    idle(4);
    check("rdpush_level", 32'(level_i), 32'd64);
    check("rdpush_overflow", 32'(ovf_i), 32'd0);
    check("rdpush_head", rd_i, {16'h4003, 16'h8011});
    push_frame(fl(65), fr(65));
    idle(4);
    check("ovf_flag", 32'(ovf_i), 32'd1);
    check("ovf_level", 32'(level_i), 32'd64);
`ifdef AUDIO_ADC_RX_DROPCNT_EN
    check("ovf_drop_cnt", 32'(drop_i), 32'd1);
`endif
    for (int i = 0; i < 64; i++) begin
      do_read();
      idle(1);
    end
    check("drain_empty", 32'(empty_i), 32'd1);

    // clear in the middle of a right slot with three pairs held
    for (int i = 100; i < 103; i++) push_frame(fl(i), fr(i));
    idle(4);
    check("pre_clear_level", 32'(level_i), 32'd3);
    hook_kind = 1; hook_ch = 1; hook_pos = 8;
    send_frame(16'hDEAD, 16'hBEEF);
    hook_kind = 0;
    model_clear();
    idle(4);
    check("clear_level", 32'(level_i), 32'd0);
    check("clear_overflow", 32'(ovf_i), 32'd0);
    push_frame(16'h1357, 16'h2468);
    idle(4);
    check("post_clear_pair", rd_i, 32'h13572468);

    // reset in the middle of a right slot with three pairs held
    for (int i = 110; i < 112; i++) push_frame(fl(i), fr(i));
    idle(4);
    check("pre_reset_level", 32'(level_i), 32'd3);
    hook_kind = 2; hook_ch = 1; hook_pos = 8;
    send_frame(16'hCAFE, 16'hF00D);
    hook_kind = 0;
    model_clear();
    idle(4);
    check("reset_level", 32'(level_i), 32'd0);
    check("reset_empty", 32'(empty_i), 32'd1);
    push_frame(16'h7E57, 16'h0001);
    idle(4);
    check("post_reset_pair", rd_i, 32'h7E570001);
    check("post_reset_level", 32'(level_i), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
